sevenseg_scan: RTL
==================

// Module: sevenseg_scan
// PURPOSE
//  Time-multiplexed driver for the Nexys3 4-digit seven-segment display; downstream of game_interface.
//  Consumes the dig3..dig0 codes and dp flags written by the PicoBlaze firmware.
//  Latches them once per scan frame (tear-free) and decodes to segment patterns.
//  Drives active-low anodes, segments and decimal point with an anti-ghost blanking gap.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per digit slot (100 MHz -> 2 kHz slot, 500 Hz frame); legal >= 4
//  BLANK_CYC  500    cycles at start of each slot with all anodes off; legal 0..SCAN_DIV-2
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-low reset
//  dig3        in   5  code for leftmost digit (an[3])
//  dig2        in   5  code for digit 2
//  dig1        in   5  code for digit 1
//  dig0        in   5  code for rightmost digit (an[0])
//  dp          in   4  decimal point per digit, 1 = lit; dp[i] pairs with an[i]
//  brightness  in   4  (SEVSEG_DIM_EN only) on-time in sixteenths of the slot
//  an          out  4  anode enables, active-low
//  seg         out  7  {g,f,e,d,c,b,a}, active-low
//  dp_n        out  1  decimal point, active-low
//  frame_tick  out  1  1-cycle pulse when the shadow registers reload
// BEHAVIOUR
//  Reset (rst=0, async): an=4'hF, seg=7'h7F, dp_n=1, frame_tick=0.
//   Also: div_cnt=0, idx=0, shadow digits=5'h10 (blank), shadow dp=0.
//  div_cnt counts 0..SCAN_DIV-1 and wraps; tick = (div_cnt==SCAN_DIV-1).
//  On tick: idx advances 0->1->2->3->0; idx 2 bits, wraps silently.
//  On tick with idx==3: shadow <= {dig3..dig0, dp} sampled on that edge; frame_tick=1 next cycle.
//   Input changes mid-frame are invisible until the next frame reload.
//  First reload occurs at the first 3->0 wrap after reset; display stays blank until then.
//  Outputs registered, updated one cycle after the counter state that selects them.
//  Slot phase: div_cnt < BLANK_CYC -> an=4'hF; else an = ~(4'b0001 << idx).
//  seg/dp_n always reflect shadow[idx] decode, regardless of blanking.
//  Decode 5'h00-5'h0F: hex glyphs 0-9, A, b, C, d, E, F (e.g. 0 -> 7'h40, 8 -> 7'h00).
//  Decode 5'h10: blank (7'h7F); 5'h11: '-' (7'h3F); 5'h12: 'P' (7'h0C); 5'h13: 'L' (7'h47).
//  Decode 5'h14: 'U' (7'h41); 5'h15: 'r' (7'h2F); 5'h16: 'o' (7'h23); 5'h17: 'n' (7'h2B).
//  Decode 5'h18-5'h1F: blank.
//  dp_n = ~shadow_dp[idx].
//  Reset asserted mid-frame: immediate blank; restart from idx=0, div_cnt=0.
//  No handshake with the firmware; inputs are treated as quasi-static register outputs.
// CONFIGURATION
//  SEVSEG_DIM_EN defined: adds brightness port.
//   Anode enabled only while BLANK_CYC <= div_cnt < BLANK_CYC + on_len.
//   on_len = ((SCAN_DIV-BLANK_CYC) * brightness) >> 4; brightness=0 -> always off.
//   brightness is sampled with the shadow registers at frame reload.
//  SEVSEG_DIM_EN undefined: brightness port absent; anode on for the full non-blank part of the slot.
// TESTING  (SCAN_DIV=8, BLANK_CYC=2)
//  Reset held low -> an=F, seg=7F, dp_n=1.
//   Release; an stays F until first frame_tick (~33 clk), then digits appear.
//  dig3..0=1,2,3,4, dp=4'b0010 -> an[0] slot shows seg=7'h19.
//   an[1] slot shows 7'h30 with dp_n=0; an[3] slot shows 7'h79.
//  Each slot: an=F for exactly 2 cycles, then one-hot-low for 6; frame period 32 clk.
//   frame_tick pulses once per 32.
//  Change dig0 from 4 to 5'h11 while idx=1 -> an[0] shows 7'h19 until next frame_tick.
//   Shows 7'h3F after it.
//  dig=5'h1A on all digits -> seg=7'h7F in every slot; anodes still cycle.
//  DIM_EN, brightness=8 -> 3 on-cycles per slot.
//   brightness=0 -> an=F always; brightness=15 -> 5 on-cycles per slot.
//  rst pulsed low for 1 cycle while idx=2 -> outputs blank the same cycle.
//   After release, scan restarts at idx=0 with blank shadow.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Four-digit seven-segment scan driver; define SEVSEG_DIM_EN to add the brightness (dimming) input.
// Outputs are registered one clk after the scan counter state that selects them; there is no backpressure and the inputs are treated as quasi-static.
module sevenseg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] dig3,
  input  logic [4:0] dig2,
  input  logic [4:0] dig1,
  input  logic [4:0] dig0,
  input  logic [3:0] dp,
`ifdef SEVSEG_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]   div_cnt;
  logic [1:0]      idx;
  logic            tick;
  logic            reload;
  logic [3:0][4:0] sh_dig;
  logic [3:0]      sh_dp;
  // Keeps the anodes dark until the first frame of real data has been latched.
  logic            live;
  logic [31:0]     cnt32;
  logic            anode_on;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    s = 7'h7F;
    case (code)
      5'h00: s = 7'h40;
      5'h01: s = 7'h79;
      5'h02: s = 7'h24;
      5'h03: s = 7'h30;
      5'h04: s = 7'h19;
      5'h05: s = 7'h12;
      5'h06: s = 7'h02;
      5'h07: s = 7'h78;
      5'h08: s = 7'h00;
      5'h09: s = 7'h10;
      5'h0A: s = 7'h08;
      5'h0B: s = 7'h03;
      5'h0C: s = 7'h46;
      5'h0D: s = 7'h21;
      5'h0E: s = 7'h06;
      5'h0F: s = 7'h0E;
      5'h11: s = 7'h3F;
      5'h12: s = 7'h0C;
      5'h13: s = 7'h47;
      5'h14: s = 7'h41;
      5'h15: s = 7'h2F;
      5'h16: s = 7'h23;
      5'h17: s = 7'h2B;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick   = (div_cnt == CW'(SCAN_DIV - 1));
  assign reload = tick && (idx == 2'd3);
  assign cnt32  = 32'(div_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef SEVSEG_DIM_EN
  logic [3:0]  sh_br;
  logic [31:0] on_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_br <= 4'd0;
    end else if (reload) begin
      sh_br <= brightness;
    end
  end

  assign on_len   = (32'(SCAN_DIV - BLANK_CYC) * {28'd0, sh_br}) >> 4;
  assign anode_on = (cnt32 >= 32'(BLANK_CYC)) && (cnt32 < 32'(BLANK_CYC) + on_len);
`else
  assign anode_on = (cnt32 >= 32'(BLANK_CYC));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_dig <= {4{5'h10}};
      sh_dp  <= 4'd0;
      live   <= 1'b0;
    end else if (reload) begin
      sh_dig <= {dig3, dig2, dig1, dig0};
      sh_dp  <= dp;
      live   <= 1'b1;
    end
  end

  always_comb begin
    an_d  = 4'hF;
    seg_d = decode(sh_dig[idx]);
    if (live && anode_on) begin
      an_d = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= ~sh_dp[idx];
      frame_tick <= reload;
    end
  end

endmodule
